// File: rtl/cacheline_adaptor.sv
// Splits one cache-line read/write into BURST_W-wide memory beats and returns
// a single completion pulse to the cache once the whole line has moved.
module cacheline_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BEATS-1:0][BURST_W-1:0] buf_q, buf_d;
  logic [LINE_W-1:0]             line_q, line_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic                          last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
    end
  end

  // line_q is a separate copy so a write (which reloads buf_q) leaves the
  // last read line visible; it is loaded on the final read beat so it is
  // already valid in the DONE cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    line_d    = line_q;
    addr_d    = addr_q;
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (write_i) begin
          buf_d   = line_i;
          addr_d  = address_i & ~OFFS_MASK;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & ~OFFS_MASK;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          buf_d[cnt_q] = burst_i;
          if (last_beat) begin
            cnt_d   = '0;
            line_d  = buf_d;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_o    = (state_q == READ);
    write_o   = (state_q == WRITE);
    resp_o    = (state_q == DONE);
    burst_o   = (state_q == WRITE) ? buf_q[cnt_q] : '0;
    line_o    = line_q;
    address_o = addr_q;
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboarded bench for cacheline_adaptor: directed line reads/writes with a
// monitor checking every write beat and every completion against queued values.
module tb_cacheline_adaptor;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned ADDR_W  = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_o;
  logic [BURST_W-1:0] burst_i;
  logic               resp_i;

  cacheline_adaptor #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .burst_o  (burst_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [LINE_W-1:0]  resp_q[$];
  logic [BURST_W-1:0] beat_q[$];
  logic [LINE_W-1:0]  model_line = '0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, LINE_W'(act), LINE_W'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    logic [LINE_W-1:0]  exp_line;
    logic [BURST_W-1:0] exp_beat;
    if (resp_o === 1'b1) begin
      if (resp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_o=1 expected no completion");
      end else begin
        exp_line = resp_q.pop_front();
        check("resp_line", line_o, exp_line);
      end
    end
    if (write_o === 1'b1 && resp_i === 1'b1) begin
      if (beat_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got burst_o=%h expected no beat", burst_o);
      end else begin
        exp_beat = beat_q.pop_front();
        check("write_beat", LINE_W'(burst_o), LINE_W'(exp_beat));
      end
    end
  end

  task automatic do_read(input logic [ADDR_W-1:0] addr,
                         input logic [3:0][BURST_W-1:0] b,
                         input logic [15:0] pat, input int unsigned npat,
                         input bit keep, input logic [ADDR_W-1:0] next_addr);
    int unsigned k = 0;
    address_i  = addr;
    read_i     = 1'b1;
    model_line = b;
    resp_q.push_back(b);
    tick();
    check("rd_addr", LINE_W'(address_o), LINE_W'(addr & ~32'h1f));
    chk1("rd_write_o", write_o, 1'b0);
    address_i = 32'hDEAD_BEEF;
    for (int i = 0; i < int'(npat); i++) begin
      chk1("rd_read_o_held", read_o, 1'b1);
      resp_i  = pat[i];
      burst_i = pat[i] ? b[k] : 64'h0BAD_0BAD_0BAD_0BAD;
      if (pat[i]) k++;
      tick();
    end
    resp_i = 1'b0;
    chk1("rd_done_resp", resp_o, 1'b1);
    chk1("rd_done_read_o", read_o, 1'b0);
    if (keep) begin
      address_i = next_addr;
      resp_i    = 1'b1;
      burst_i   = 64'hFFFF_0000_FFFF_0000;
    end else begin
      read_i = 1'b0;
    end
    tick();
    chk1("rd_idle_resp", resp_o, 1'b0);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr,
                          input logic [3:0][BURST_W-1:0] l,
                          input int unsigned delay, input logic also_read);
    address_i = addr;
    line_i    = l;
    write_i   = 1'b1;
    read_i    = also_read;
    for (int i = 0; i < 4; i++) beat_q.push_back(l[i]);
    resp_q.push_back(model_line);
    tick();
    chk1("wr_write_o", write_o, 1'b1);
    chk1("wr_read_o", read_o, 1'b0);
    check("wr_addr", LINE_W'(address_o), LINE_W'(addr & ~32'h1f));
    line_i    = ~l;
    address_i = 32'h5555_5555;
    for (int i = 0; i < int'(delay); i++) begin
      if (i == int'(delay) - 1) begin
        chk1("wr_wait_write_o", write_o, 1'b1);
        check("wr_wait_burst", LINE_W'(burst_o), LINE_W'(l[0]));
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    chk1("wr_done_resp", resp_o, 1'b1);
    chk1("wr_done_write_o", write_o, 1'b0);
    write_i = 1'b0;
    read_i  = 1'b0;
    tick();
    chk1("wr_idle_resp", resp_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][BURST_W-1:0] l;
    rst = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    tick();
    tick();
    chk1("rst_read_o", read_o, 1'b0);
    chk1("rst_write_o", write_o, 1'b0);
    chk1("rst_resp_o", resp_o, 1'b0);
    check("rst_addr", LINE_W'(address_o), '0);
    check("rst_burst", LINE_W'(burst_o), '0);
    check("rst_line", line_o, '0);
    rst = 1'b0;
    tick();

    // Plain read, four consecutive beats.
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, l, 16'h000F, 4, 1'b0, '0);
    check("rd1_line_held", line_o, l);

    // Write after a 10-cycle memory delay.
    do_write(32'h0000_2040, {64'hD, 64'hC, 64'hB, 64'hA}, 10, 1'b0);

    // Stalled read: beats on pattern 1,0,0,1,1,0,1.
    l = {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
         64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
    do_read(32'h8000_00FF, l, 16'b101_1001, 7, 1'b0, '0);

    // Simultaneous read and write: write wins, line_o keeps the last read.
    do_write(32'h0000_3000, {64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F,
                             64'hCAFE_F00D_CAFE_F00D, 64'h0123_4567_89AB_CDEF},
             2, 1'b1);
    check("rw_line_unchanged", line_o, l);

    // Back-to-back reads with a stray beat strobe in DONE and IDLE.
    l = {64'h0000_0000_0000_00D3, 64'h0000_0000_0000_00C2,
         64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0};
    do_read(32'h0000_0100, l, 16'h000F, 4, 1'b1, 32'h0000_0220);
    l = {64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666,
         64'h5555_5555_5555_5555, 64'h9999_9999_9999_9999};
    do_read(32'h0000_0220, l, 16'h000F, 4, 1'b0, '0);

    // Reset after two beats of a read.
    address_i = 32'h0000_4000;
    read_i    = 1'b1;
    tick();
    resp_i = 1'b1; burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
    tick();
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    resp_i = 1'b0;
    rst    = 1'b1;
    tick();
    chk1("mid_rst_read_o", read_o, 1'b0);
    chk1("mid_rst_resp_o", resp_o, 1'b0);
    check("mid_rst_line", line_o, '0);
    check("mid_rst_addr", LINE_W'(address_o), '0);
    model_line = '0;
    rst    = 1'b0;
    read_i = 1'b0;
    tick();
    chk1("post_rst_idle", read_o, 1'b0);
    tick();
    l = {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707,
         64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505};
    do_read(32'h0000_4010, l, 16'h000F, 4, 1'b0, '0);

    tick();
    tick();
    check("resp_queue_empty", LINE_W'(resp_q.size()), '0);
    check("beat_queue_empty", LINE_W'(beat_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
